// File: rtl/nx_indirect_access_arb.sv
// -----------------------------------------------------------------------------
// nx_indirect_access_arb
//
// Single-port RAM arbiter between the indirect-access controller's software
// port and the owning datapath's hardware port. Hardware traffic normally wins.
// A starvation counter bounds how long a pending software request can be held
// off. The software request also wins outright while the controller signals
// yield, while its init sweep is running (reset), or while the hardware port is
// disabled.
//
// Parameters
//   N_DATA_BITS  : RAM word width
//   N_ADDR_BITS  : RAM address width
//   MAX_HW_BURST : max consecutive hardware accesses while software waits (1..255)
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   sw_cs/sw_we/sw_add/sw_wdat         software request (held until grant)
//   yield, reset, enable               controller arbitration hints
//   grant                              software access performed this cycle
//   sw_rdat                            software read data (held between reads)
//   hw_cs/hw_we/hw_add/hw_wdat         hardware request (held while stalled)
//   hw_stall                           hardware request not accepted this cycle
//   hw_rvld, hw_rdat                   hardware read return
//   mem_cs/mem_we/mem_add/mem_wdat     RAM command, all zero when idle
//   mem_rdat                           RAM read data, one cycle after select
//   stall_cnt                          saturating count of hw_stall cycles
// -----------------------------------------------------------------------------
module nx_indirect_access_arb #(
  parameter int N_DATA_BITS  = 96,
  parameter int N_ADDR_BITS  = 9,
  parameter int MAX_HW_BURST = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_cs,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  input  logic                   yield,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   grant,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  input  logic                   hw_cs,
  input  logic                   hw_we,
  input  logic [N_ADDR_BITS-1:0] hw_add,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic                   hw_stall,
  output logic                   hw_rvld,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [N_ADDR_BITS-1:0] mem_add,
  output logic [N_DATA_BITS-1:0] mem_wdat,
  input  logic [N_DATA_BITS-1:0] mem_rdat,
  output logic [15:0]            stall_cnt
);

  localparam int STARVE_W = $clog2(MAX_HW_BURST + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_HW_BURST);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [STARVE_W-1:0] starve_next(
    input logic [STARVE_W-1:0] cnt,
    input logic                clr,
    input logic                inc
  );
    if (clr)      return '0;
    else if (inc) return cnt + 1'b1;
    else          return cnt;
  endfunction

  logic [STARVE_W-1:0]    starve_cnt;
  logic                   force_sw;
  logic                   hw_go;
  logic                   sw_rd_p1;
  logic                   hw_rd_p1;
  logic [N_DATA_BITS-1:0] sw_hold;

  // ---- stage p0: arbitration and RAM command ----
  always_comb begin
    force_sw = (starve_cnt == STARVE_MAX);
    grant    = sw_cs & (~hw_cs | yield | reset | ~enable | force_sw);
    hw_stall = hw_cs & (grant | ~enable);
    hw_go    = hw_cs & ~hw_stall;
    mem_cs   = grant | hw_go;

    mem_we   = 1'b0;
    mem_add  = '0;
    mem_wdat = '0;
    if (grant) begin
      mem_we   = sw_we;
      mem_add  = sw_add;
      mem_wdat = sw_wdat;
    end else if (hw_go) begin
      mem_we   = hw_we;
      mem_add  = hw_add;
      mem_wdat = hw_wdat;
    end
  end

  // The only way software can be refused is a granted hardware access, so
  // every non-granted pending cycle counts one hardware access against it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      sw_rd_p1   <= 1'b0;
      hw_rd_p1   <= 1'b0;
      sw_hold    <= '0;
      stall_cnt  <= '0;
    end else begin
      starve_cnt <= starve_next(starve_cnt, grant | ~sw_cs, hw_go & sw_cs);
      sw_rd_p1   <= grant & ~sw_we;
      hw_rd_p1   <= hw_go & ~hw_we;
      if (sw_rd_p1) sw_hold <= mem_rdat;
      if (hw_stall) stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  // ---- stage p1: read return ----
  // sw_hold keeps the last software read word so the controller sees a
  // stable value even while the RAM output moves on for hardware reads.
  always_comb begin
    hw_rvld = hw_rd_p1;
    hw_rdat = mem_rdat;
    sw_rdat = sw_rd_p1 ? mem_rdat : sw_hold;
  end

endmodule

// File: tb/tb_nx_indirect_access_arb.sv
module tb_nx_indirect_access_arb;
  logic        clk;
  logic        rst_n;
  logic        sw_cs, sw_we;
  logic [8:0]  sw_add;
  logic [95:0] sw_wdat;
  logic        yield, reset, enable;
  logic        grant;
  logic [95:0] sw_rdat;
  logic        hw_cs, hw_we;
  logic [8:0]  hw_add;
  logic [95:0] hw_wdat;
  logic        hw_stall, hw_rvld;
  logic [95:0] hw_rdat;
  logic        mem_cs, mem_we;
  logic [8:0]  mem_add;
  logic [95:0] mem_wdat;
  logic [95:0] mem_rdat;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  nx_indirect_access_arb #(.N_DATA_BITS(96), .N_ADDR_BITS(9), .MAX_HW_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sw_cs(sw_cs), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
    .yield(yield), .reset(reset), .enable(enable),
    .grant(grant), .sw_rdat(sw_rdat),
    .hw_cs(hw_cs), .hw_we(hw_we), .hw_add(hw_add), .hw_wdat(hw_wdat),
    .hw_stall(hw_stall), .hw_rvld(hw_rvld), .hw_rdat(hw_rdat),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_add(mem_add), .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  // Advance to just after the next rising edge; new inputs go here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sw_cs = 0; sw_we = 0; sw_add = '0; sw_wdat = '0;
    yield = 0; reset = 0; enable = 1;
    hw_cs = 0; hw_we = 0; hw_add = '0; hw_wdat = '0;
    mem_rdat = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    next_cycle(); next_cycle();
    #4;
    tests++; if (hw_rvld !== 1'b0) begin fails++; $display("FAIL reset_hw_rvld got=%0h exp=0", hw_rvld); end
    tests++; if (sw_rdat !== 96'h0) begin fails++; $display("FAIL reset_sw_rdat got=%0h exp=0", sw_rdat); end
    tests++; if (grant !== 1'b0 || mem_cs !== 1'b0 || hw_stall !== 1'b0) begin fails++; $display("FAIL reset_comb got grant=%0b mem_cs=%0b hw_stall=%0b exp=0", grant, mem_cs, hw_stall); end
    tests++; if (stall_cnt !== 16'h0) begin fails++; $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); end
    next_cycle();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_sw_write();
    sw_cs = 1; sw_we = 1; sw_add = 9'h005; sw_wdat = 96'hA5;
    #4;
    tests++; if (grant !== 1'b1 || mem_cs !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("FAIL swwr_ctrl got grant=%0b cs=%0b we=%0b exp=1,1,1", grant, mem_cs, mem_we); end
    tests++; if (mem_add !== 9'h005 || mem_wdat !== 96'hA5) begin fails++; $display("FAIL swwr_addr_data got add=%0h wdat=%0h exp=5,a5", mem_add, mem_wdat); end
    next_cycle();
    idle_inputs();
    mem_rdat = 96'hDEAD;
    #4;
    tests++; if (hw_rvld !== 1'b0 || sw_rdat !== 96'h0) begin fails++; $display("FAIL swwr_no_read got rvld=%0b sw_rdat=%0h exp=0,0", hw_rvld, sw_rdat); end
    tests++; if (mem_cs !== 1'b0 || mem_add !== 9'h0 || mem_wdat !== 96'h0) begin fails++; $display("FAIL idle_mem got cs=%0b add=%0h wdat=%0h exp=0", mem_cs, mem_add, mem_wdat); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_sw_read();
    sw_cs = 1; sw_we = 0; sw_add = 9'h007;
    #4;
    tests++; if (grant !== 1'b1 || mem_we !== 1'b0 || mem_add !== 9'h007) begin fails++; $display("FAIL swrd_cmd got grant=%0b we=%0b add=%0h exp=1,0,7", grant, mem_we, mem_add); end
    next_cycle();
    sw_cs = 0; mem_rdat = 96'h1234;
    #4;
    tests++; if (sw_rdat !== 96'h1234 || hw_rvld !== 1'b0) begin fails++; $display("FAIL swrd_t1 got sw_rdat=%0h rvld=%0b exp=1234,0", sw_rdat, hw_rvld); end
    next_cycle();
    mem_rdat = 96'h0;
    #4;
    tests++; if (sw_rdat !== 96'h1234 || hw_rvld !== 1'b0) begin fails++; $display("FAIL swrd_t2_hold got sw_rdat=%0h rvld=%0b exp=1234,0", sw_rdat, hw_rvld); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    sw_cs = 1; sw_we = 0; sw_add = 9'h001;
    #4;
    tests++; if (grant !== 1'b1 || mem_add !== 9'h001) begin fails++; $display("FAIL b2b_first got grant=%0b add=%0h exp=1,1", grant, mem_add); end
    next_cycle();
    sw_add = 9'h002; mem_rdat = 96'h111;
    #4;
    tests++; if (grant !== 1'b1 || mem_add !== 9'h002 || sw_rdat !== 96'h111) begin fails++; $display("FAIL b2b_second got grant=%0b add=%0h sw_rdat=%0h exp=1,2,111", grant, mem_add, sw_rdat); end
    next_cycle();
    sw_cs = 0; mem_rdat = 96'h222;
    #4;
    tests++; if (sw_rdat !== 96'h222) begin fails++; $display("FAIL b2b_data2 got=%0h exp=222", sw_rdat); end
    next_cycle();
    mem_rdat = 96'h0;
    #4;
    tests++; if (sw_rdat !== 96'h222) begin fails++; $display("FAIL b2b_hold got=%0h exp=222", sw_rdat); end
    next_cycle();
  endtask

  task automatic test_contention();
    hw_cs = 1; hw_we = 0; hw_add = 9'h010;
    sw_cs = 1; sw_we = 1; sw_add = 9'h020; sw_wdat = 96'h55;
    for (int c = 1; c <= 8; c++) begin
      mem_rdat = 96'(c);
      #4;
      tests++; if (hw_stall !== 1'b0 || grant !== 1'b0 || mem_add !== 9'h010) begin fails++; $display("FAIL cont_hw_cycle%0d got stall=%0b grant=%0b add=%0h exp=0,0,10", c, hw_stall, grant, mem_add); end
      if (c == 2) begin
        tests++; if (hw_rvld !== 1'b1 || hw_rdat !== 96'h2) begin fails++; $display("FAIL cont_hw_rvld got rvld=%0b rdat=%0h exp=1,2", hw_rvld, hw_rdat); end
      end
      next_cycle();
    end
    #4;
    tests++; if (grant !== 1'b1 || hw_stall !== 1'b1 || mem_add !== 9'h020 || mem_we !== 1'b1) begin fails++; $display("FAIL cont_force got grant=%0b stall=%0b add=%0h we=%0b exp=1,1,20,1", grant, hw_stall, mem_add, mem_we); end
    next_cycle();
    #4;
    tests++; if (grant !== 1'b0 || hw_stall !== 1'b0 || hw_rvld !== 1'b0) begin fails++; $display("FAIL cont_restart got grant=%0b stall=%0b rvld=%0b exp=0,0,0", grant, hw_stall, hw_rvld); end
    tests++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL cont_stall_cnt got=%0d exp=1", stall_cnt); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_yield();
    hw_cs = 1; hw_we = 1; hw_add = 9'h011;
    sw_cs = 1; sw_we = 1; sw_add = 9'h033; yield = 1;
    #4;
    tests++; if (grant !== 1'b1 || hw_stall !== 1'b1 || mem_add !== 9'h033) begin fails++; $display("FAIL yield got grant=%0b stall=%0b add=%0h exp=1,1,33", grant, hw_stall, mem_add); end
    next_cycle();
    idle_inputs();
    #4;
    tests++; if (stall_cnt !== 16'd2) begin fails++; $display("FAIL yield_stall_cnt got=%0d exp=2", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_enable_sweep();
    enable = 0; hw_cs = 1; hw_we = 1; hw_add = 9'h044; sw_cs = 0;
    #4;
    tests++; if (hw_stall !== 1'b1 || mem_cs !== 1'b0 || grant !== 1'b0) begin fails++; $display("FAIL disabled got stall=%0b cs=%0b grant=%0b exp=1,0,0", hw_stall, mem_cs, grant); end
    next_cycle();
    enable = 1; reset = 1; sw_cs = 1; sw_we = 1;
    for (int a = 0; a < 3; a++) begin
      sw_add = 9'(a); sw_wdat = 96'(a + 100);
      #4;
      tests++; if (grant !== 1'b1 || hw_stall !== 1'b1 || mem_add !== 9'(a)) begin fails++; $display("FAIL sweep_%0d got grant=%0b stall=%0b add=%0h exp=1,1,%0h", a, grant, hw_stall, mem_add, a); end
      next_cycle();
    end
    idle_inputs();
    #4;
    tests++; if (stall_cnt !== 16'd6) begin fails++; $display("FAIL sweep_stall_cnt got=%0d exp=6", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_hw_read();
    hw_cs = 1; hw_we = 0; hw_add = 9'h040;
    #4;
    tests++; if (mem_cs !== 1'b1 || mem_add !== 9'h040 || hw_stall !== 1'b0) begin fails++; $display("FAIL hwrd_cmd got cs=%0b add=%0h stall=%0b exp=1,40,0", mem_cs, mem_add, hw_stall); end
    next_cycle();
    hw_cs = 0; mem_rdat = 96'hBEEF;
    #4;
    tests++; if (hw_rvld !== 1'b1 || hw_rdat !== 96'hBEEF || sw_rdat !== 96'h222) begin fails++; $display("FAIL hwrd_ret got rvld=%0b rdat=%0h sw_rdat=%0h exp=1,beef,222", hw_rvld, hw_rdat, sw_rdat); end
    next_cycle();
    mem_rdat = '0;
    #4;
    tests++; if (hw_rvld !== 1'b0) begin fails++; $display("FAIL hwrd_single got=%0b exp=0", hw_rvld); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    hw_cs = 1; hw_we = 0; hw_add = 9'h050;
    #4;
    tests++; if (mem_cs !== 1'b1 || hw_stall !== 1'b0) begin fails++; $display("FAIL rst_rd_accept got cs=%0b stall=%0b exp=1,0", mem_cs, hw_stall); end
    next_cycle();
    idle_inputs();
    mem_rdat = 96'h777;
    rst_n = 0;
    #1;
    tests++; if (hw_rvld !== 1'b0 || sw_rdat !== 96'h0 || stall_cnt !== 16'h0) begin fails++; $display("FAIL rst_async got rvld=%0b sw_rdat=%0h stall_cnt=%0d exp=0,0,0", hw_rvld, sw_rdat, stall_cnt); end
    next_cycle();
    rst_n = 1;
    #4;
    tests++; if (hw_rvld !== 1'b0 || sw_rdat !== 96'h0) begin fails++; $display("FAIL rst_release got rvld=%0b sw_rdat=%0h exp=0,0", hw_rvld, sw_rdat); end
    next_cycle();
    mem_rdat = '0;
    sw_cs = 1; sw_we = 1; sw_add = 9'h0AA; sw_wdat = 96'h5A;
    #4;
    tests++; if (grant !== 1'b1 || mem_add !== 9'h0AA || mem_wdat !== 96'h5A) begin fails++; $display("FAIL rst_first_access got grant=%0b add=%0h wdat=%0h exp=1,aa,5a", grant, mem_add, mem_wdat); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sw_write();
    test_sw_read();
    test_back_to_back();
    test_contention();
    test_yield();
    test_enable_sweep();
    test_hw_read();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
